// File: rtl/transmisor_qos.sv
// rtl/transmisor_qos.sv - per-VC burst transmitter with round-robin arbitration and flow control
//
// Purpose: accepts per-VC burst commands and emits one word per cycle
// (vc_id, data_word, wr_valid) towards the QoS demux/FIFO path, honouring
// per-VC pause/resume/overflow feedback.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   enb                      global enable (freezes FSM, accept and transmit)
//   iniciar                  start pulse, only honoured in IDLE
//   cmd_valid/cmd_vc/cmd_len burst command; cmd_ready is combinational
//   pausa/continuar          per-VC pause / resume from flow control
//   error_full               per-VC overflow indication
//   vc_id/data_word/wr_valid registered word output
//   pausado                  per-VC paused flags
//   estado/tx_idle           FSM state (IDLE=0, RUN=1, HOLD=2) and idle flag
//   errores                  saturating count of error_full events
module transmisor_qos #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 4,
  parameter int MAX_LEN        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic                              iniciar,
  input  logic                              cmd_valid,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0] cmd_vc,
  input  logic [$clog2(MAX_LEN):0]          cmd_len,
  output logic                              cmd_ready,
  input  logic [QUEUE_QUANTITY-1:0]         pausa,
  input  logic [QUEUE_QUANTITY-1:0]         continuar,
  input  logic [QUEUE_QUANTITY-1:0]         error_full,
  output logic [$clog2(QUEUE_QUANTITY)-1:0] vc_id,
  output logic [DATA_BITS-1:0]              data_word,
  output logic                              wr_valid,
  output logic [QUEUE_QUANTITY-1:0]         pausado,
  output logic [1:0]                        estado,
  output logic                              tx_idle,
  output logic [7:0]                        errores
);

  localparam int VW = $clog2(QUEUE_QUANTITY);
  localparam int LW = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         rem_q [QUEUE_QUANTITY];
  logic [LW-1:0]         rem_d [QUEUE_QUANTITY];
  logic [DATA_BITS-1:0]  seq_q [QUEUE_QUANTITY];
  logic [VW-1:0]         ptr_q;
  logic [QUEUE_QUANTITY-1:0] pend, elig, pausado_d;
  logic                  found, grant_en, accept, any_next;
  logic [VW-1:0]         grant, idx;
  logic [LW-1:0]         len_clamped;
  logic [7:0]            err_cnt, errores_d;
  logic [8:0]            err_sum;

  assign cmd_ready   = enb && (rem_q[cmd_vc] == '0);
  assign accept      = cmd_valid && cmd_ready;
  assign len_clamped = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign estado      = state_q;
  assign tx_idle     = (state_q == IDLE);

  // Eligibility uses the registered pause flags, so a pause pulse only
  // takes effect from the cycle after it is seen.
  always_comb begin
    pend = '0;
    elig = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      pend[i] = (rem_q[i] != '0);
      elig[i] = pend[i] && !pausado[i];
    end
  end

  // Round-robin search starting just after the last granted VC.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= QUEUE_QUANTITY; i++) begin
      idx = VW'((int'(ptr_q) + i) % QUEUE_QUANTITY);
      if (!found && elig[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_en = (state_q == RUN) && enb && found;

  // Accept and grant never target the same VC: accept needs rem==0,
  // grant needs rem!=0.
  always_comb begin
    any_next = 1'b0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      rem_d[i] = rem_q[i];
      if (grant_en && grant == VW'(i)) rem_d[i] = rem_q[i] - LW'(1);
      if (accept && cmd_vc == VW'(i))  rem_d[i] = len_clamped;
      if (rem_d[i] != '0) any_next = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enb) begin
      case (state_q)
        IDLE:    if (iniciar && |pend) state_d = RUN;
        RUN: begin
          if (!any_next)               state_d = IDLE;
          else if (|pend && !(|elig))  state_d = HOLD;
        end
        HOLD: begin
          if (|elig)                   state_d = RUN;
          else if (!any_next)          state_d = IDLE;
        end
        default:                       state_d = IDLE;
      endcase
    end
  end

  // Flow control and error counting run regardless of enb.
  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      err_cnt = err_cnt + 8'(error_full[i]);
      if (pausa[i] || error_full[i]) pausado_d[i] = 1'b1;
      else if (continuar[i])         pausado_d[i] = 1'b0;
      else                           pausado_d[i] = pausado[i];
    end
    err_sum   = {1'b0, errores} + {1'b0, err_cnt};
    errores_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= VW'(QUEUE_QUANTITY - 1);
      vc_id     <= '0;
      data_word <= '0;
      wr_valid  <= 1'b0;
      pausado   <= '0;
      errores   <= '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        rem_q[i] <= '0;
        seq_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pausado  <= pausado_d;
      errores  <= errores_d;
      wr_valid <= grant_en;
      for (int i = 0; i < QUEUE_QUANTITY; i++) rem_q[i] <= rem_d[i];
      if (grant_en) begin
        vc_id        <= grant;
        data_word    <= seq_q[grant];
        seq_q[grant] <= seq_q[grant] + DATA_BITS'(1);
        ptr_q        <= grant;
      end
    end
  end

endmodule

// File: tb/tb_transmisor_qos.sv
// tb/tb_transmisor_qos.sv - self-checking bench for transmisor_qos
module tb_transmisor_qos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b1;
  logic       iniciar = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_vc = '0;
  logic [4:0] cmd_len = '0;
  logic       cmd_ready;
  logic [3:0] pausa = '0, continuar = '0, error_full = '0;
  logic [1:0] vc_id;
  logic [3:0] data_word;
  logic       wr_valid;
  logic [3:0] pausado;
  logic [1:0] estado;
  logic       tx_idle;
  logic [7:0] errores;

  int n_checks = 0;
  int n_fail   = 0;

  transmisor_qos #(.QUEUE_QUANTITY(4), .DATA_BITS(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar),
    .cmd_valid(cmd_valid), .cmd_vc(cmd_vc), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .pausa(pausa), .continuar(continuar), .error_full(error_full),
    .vc_id(vc_id), .data_word(data_word), .wr_valid(wr_valid),
    .pausado(pausado), .estado(estado), .tx_idle(tx_idle), .errores(errores)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] vc;
    logic [4:0] len;
    logic       ini;
    logic [3:0] pau, con, err;
    logic       ewr;
    logic [1:0] evc;
    logic [3:0] edata;
    logic [1:0] est;
    logic [3:0] epau;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic cv, logic [1:0] vc, logic [4:0] len, logic ini,
                             logic ewr, logic [1:0] evc, logic [3:0] ed, logic [1:0] est);
    vec_t x;
    x.rst = r; x.cv = cv; x.vc = vc; x.len = len; x.ini = ini;
    x.pau = '0; x.con = '0; x.err = '0;
    x.ewr = ewr; x.evc = evc; x.edata = ed; x.est = est; x.epau = '0;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic exp_word(input string name, input int vc, input int d);
    check({name, ".wr_valid"}, wr_valid, 1);
    check({name, ".vc_id"}, vc_id, vc);
    check({name, ".data"}, data_word, d);
  endtask

  task automatic cmd(input logic [1:0] vc, input logic [4:0] len);
    cmd_valid = 1'b1; cmd_vc = vc; cmd_len = len;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    // Single burst on VC2, then round-robin over four VCs (fresh pointer).
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, 3, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 2, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 2, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 2, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 2'(i), 2, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(v(0, 0, 0, 0, 0, 1, 2'(i % 4), 4'(i / 4), (i == 7) ? 2'd0 : 2'd1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; cmd_valid = tbl[k].cv; cmd_vc = tbl[k].vc; cmd_len = tbl[k].len;
      iniciar = tbl[k].ini; pausa = tbl[k].pau; continuar = tbl[k].con; error_full = tbl[k].err;
      cyc();
      check($sformatf("vec%0d.wr_valid", k), wr_valid, tbl[k].ewr);
      if (tbl[k].ewr) begin
        check($sformatf("vec%0d.vc_id", k), vc_id, tbl[k].evc);
        check($sformatf("vec%0d.data", k), data_word, tbl[k].edata);
      end
      check($sformatf("vec%0d.estado", k), estado, tbl[k].est);
      check($sformatf("vec%0d.tx_idle", k), tx_idle, tbl[k].est == 2'd0);
      check($sformatf("vec%0d.pausado", k), pausado, tbl[k].epau);
      if (tbl[k].rst) begin
        check($sformatf("vec%0d.errores", k), errores, 0);
        check($sformatf("vec%0d.data_rst", k), data_word, 0);
        check($sformatf("vec%0d.vc_rst", k), vc_id, 0);
      end
    end
    rst = 1'b0; cmd_valid = 1'b0; iniciar = 1'b0;

    // Pause VC1 mid-run, resume, then pause+resume in the same cycle.
    do_reset();
    cmd(0, 3); cmd(1, 3); cmd(2, 3);
    start();
    cyc(); exp_word("pz.a", 0, 0);
    pausa = 4'b0010; cyc(); pausa = '0;
    exp_word("pz.b", 1, 0); check("pz.pausado_set", pausado, 4'b0010);
    cyc(); exp_word("pz.c", 2, 0);
    cyc(); exp_word("pz.d", 0, 1);
    cyc(); exp_word("pz.e", 2, 1);
    continuar = 4'b0010; cyc(); continuar = '0;
    exp_word("pz.f", 0, 2); check("pz.pausado_clr", pausado, 0);
    cyc(); exp_word("pz.g", 1, 1);
    cyc(); exp_word("pz.h", 2, 2);
    cyc(); exp_word("pz.i", 1, 2); check("pz.estado_end", estado, 0);
    pausa = 4'b0010; continuar = 4'b0010; cyc(); pausa = '0; continuar = '0;
    check("pz.set_wins", pausado, 4'b0010);
    continuar = 4'b0010; cyc(); continuar = '0;
    check("pz.clear_again", pausado, 0);

    // HOLD: only VC0 pending and paused.
    do_reset();
    cmd(0, 4);
    start();
    cyc(); exp_word("hd.a", 0, 0);
    pausa = 4'b0001; cyc(); pausa = '0;
    exp_word("hd.b", 0, 1);
    cyc(); check("hd.hold_state", estado, 2); check("hd.hold_wr", wr_valid, 0);
    cyc(); check("hd.hold_state2", estado, 2); check("hd.hold_wr2", wr_valid, 0);
    continuar = 4'b0001; cyc(); continuar = '0;
    check("hd.still_hold", estado, 2); check("hd.pausado", pausado, 0);
    cyc(); check("hd.run_again", estado, 1); check("hd.run_wr", wr_valid, 0);
    cyc(); exp_word("hd.c", 0, 2);
    cyc(); exp_word("hd.d", 0, 3); check("hd.idle", estado, 0);

    // Enable low freezes state and blocks commands.
    do_reset();
    cmd(0, 2);
    start();
    enb = 1'b0; cmd_valid = 1'b1; cmd_vc = 1; cmd_len = 3;
    #1 check("en.cmd_ready_low", cmd_ready, 0);
    cyc(); check("en.wr_frozen", wr_valid, 0); check("en.state_frozen", estado, 1);
    cyc(); check("en.wr_frozen2", wr_valid, 0);
    enb = 1'b1; cmd_valid = 1'b0;
    cyc(); exp_word("en.a", 0, 0);
    cyc(); exp_word("en.b", 0, 1); check("en.idle_no_vc1", estado, 0);

    // Overflow errors: saturation and pause from error_full.
    do_reset();
    error_full = 4'b1001;
    cyc(); check("er.first", errores, 2); check("er.pausado", pausado, 4'b1001);
    repeat (199) cyc();
    error_full = '0;
    check("er.saturated", errores, 255);
    cyc(); check("er.pausado_hold", pausado, 4'b1001);
    continuar = 4'b1001; cyc(); continuar = '0;
    check("er.pausado_clr", pausado, 0); check("er.errores_kept", errores, 255);

    // Asynchronous reset mid-burst.
    pausa = 4'b0100; cyc(); pausa = '0;
    cmd(3, 5);
    start();
    cyc(); exp_word("rs.a", 3, 0);
    #2 rst = 1'b1;
    #1;
    check("rs.wr_valid", wr_valid, 0); check("rs.vc_id", vc_id, 0);
    check("rs.data", data_word, 0); check("rs.estado", estado, 0);
    check("rs.tx_idle", tx_idle, 1); check("rs.pausado", pausado, 0);
    check("rs.errores", errores, 0);
    cyc(); rst = 1'b0; cmd_vc = 3;
    #1 check("rs.rem_clear", cmd_ready, 1);
    cyc();
    cmd(3, 1);
    start();
    cyc(); exp_word("rs.seq_clear", 3, 0); check("rs.end", estado, 0);

    // Sequence wrap and length clamp.
    do_reset();
    cmd(0, 16);
    start();
    for (int k = 0; k < 16; k++) begin
      cyc(); exp_word($sformatf("wr.w%0d", k), 0, k);
    end
    check("wr.idle16", estado, 0);
    cmd(0, 4);
    start();
    for (int k = 0; k < 4; k++) begin
      cyc(); exp_word($sformatf("wr.x%0d", k), 0, k);
    end
    cmd(1, 31);
    start();
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (wr_valid) begin
        check($sformatf("wr.c%0d", cnt), data_word, cnt % 16);
        cnt++;
      end
    end
    check("wr.clamp_count", cnt, 16);
    check("wr.clamp_idle", estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transmisor_qos.md
Name: transmisor_qos

Overview:
- Upstream traffic source for the QoS block. It accepts per-VC burst commands and drives one word per cycle (vc_id, data_word, wr_valid) into the QoS demux/FIFO path.
- It honours per-VC flow-control feedback (pausa, continuar, error_full) coming back from the QoS flow control.
- It arbitrates round-robin among VCs that have pending, non-paused traffic.
- It is the sending end of the same VC/flow-control interface.

Parameters:
- QUEUE_QUANTITY, 4: number of virtual channels.
- DATA_BITS, 4: data_word width; matches the QoS word width.
- MAX_LEN, 16: maximum burst length per command.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- enb  in  1: global enable. When low: no command accept, no transmit, wr_valid=0, state frozen.
- iniciar  in  1: start pulse, IDLE->RUN.
- cmd_valid  in  1: burst command request.
- cmd_vc  in  $clog2(QUEUE_QUANTITY): command target VC.
- cmd_len  in  $clog2(MAX_LEN)+1: burst length in words.
- cmd_ready  out  1: command accepted this cycle when cmd_valid&&cmd_ready.
- pausa  in  QUEUE_QUANTITY: per-VC pause pulse/level from flow control.
- continuar  in  QUEUE_QUANTITY: per-VC resume pulse/level from flow control.
- error_full  in  QUEUE_QUANTITY: per-VC overflow indication from QoS.
- vc_id  out  $clog2(QUEUE_QUANTITY): VC of current word.
- data_word  out  DATA_BITS: payload.
- wr_valid  out  1: word valid this cycle.
- pausado  out  QUEUE_QUANTITY: per-VC paused flags.
- estado  out  2: FSM state, IDLE=0, RUN=1, HOLD=2.
- tx_idle  out  1: 1 iff estado==IDLE.
- errores  out  8: saturating count of error_full events.

Behaviour:

Reset
- vc_id=0, data_word=0, wr_valid=0, pausado=0, estado=IDLE, tx_idle=1, errores=0.
- rem[i]=0, seq[i]=0, RR pointer=QUEUE_QUANTITY-1 (first grant goes to VC0).

Commands
- cmd_ready is combinational: cmd_ready = enb && rem[cmd_vc]==0.
- On accept, rem[cmd_vc] <= min(cmd_len, MAX_LEN).
- cmd_len=0 is accepted as a no-op.
- Commands are accepted in any state.

Flow control (updates even when enb=0, so no pulses are lost)
- pausado[i] is set when pausa[i] | error_full[i].
- pausado[i] is cleared when continuar[i] and neither set source is active.
- Set wins over clear in the same cycle.
- Each cycle with any error_full bit high: errores += popcount(error_full), saturating at 255.

Eligibility and arbitration
- elig[i] = rem[i]!=0 && !pausado[i], using the registered pausado value.
- In RUN with enb=1 and any elig: grant g = first eligible VC searching from pointer+1 with wrap.
- On grant, next edge: wr_valid<=1, vc_id<=g, data_word<=seq[g], seq[g]++ (mod 2^DATA_BITS), rem[g]--, pointer<=g.
- Otherwise wr_valid<=0.
- All outputs are registered: one-cycle latency from eligibility to word.
- seq[i] persists across commands and is cleared only by reset.

FSM
- IDLE -> RUN: iniciar && enb && any rem!=0. With iniciar and nothing pending, stays IDLE.
- RUN -> HOLD: any rem!=0 && no elig. wr_valid=0 while in HOLD.
- HOLD -> RUN: any elig.
- RUN/HOLD -> IDLE: all rem==0, evaluated after the decrement. The last word is still emitted with wr_valid=1 on the cycle estado becomes IDLE.
- iniciar is ignored outside IDLE.
- A command accepted while in RUN/HOLD joins arbitration on the next cycle.

Boundary conditions
- Accept and transmit can never hit the same VC in one cycle, because accept requires rem==0.
- Reset mid-burst clears all state immediately, with no partial word.

Test Plan:
- Single burst: cmd VC2 len 3, then iniciar -> wr_valid on 3 consecutive cycles, vc_id=2, data 0,1,2. Then estado=IDLE, tx_idle=1.
- Round-robin: len 2 on VCs 0-3, then iniciar -> vc_id sequence 0,1,2,3,0,1,2,3, each VC's data 0,1.
- Pause: during RUN pulse pausa[1] -> VC1 skipped, others continue. continuar[1] -> VC1 resumes with its next seq. pausa[1] and continuar[1] in the same cycle -> pausado[1]=1.
- HOLD: only VC0 pending, pausa[0] -> estado=HOLD, wr_valid=0. continuar[0] -> RUN, words resume next cycle.
- Errors and reset: error_full=4'b1001 for 200 cycles -> pausado[0]=pausado[3]=1, errores saturates at 255. Assert rst mid-burst -> all outputs return to reset values asynchronously.
- Wrap: VC0 len 16 then len 4 -> data 0..15 then 0..3. cmd_len=31 -> exactly 16 words sent.
